// File: rtl/icnd_read_arbiter_pkg.sv
// Shared definitions for the frame-memory read arbiter.
//   arb_state_e : arbiter FSM state encoding
//   WordWidth   : frame memory word width (bits)
//   StatWidth   : width of each per-channel completed-read counter
//   idx_width() : channel index width, at least one bit
package icnd_pkg;

  localparam int unsigned WordWidth = 16;
  localparam int unsigned StatWidth = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icnd_read_arbiter_if.sv
// Signal bundle between the LED channels, the read arbiter and the frame memory.
//   ch_read_request         : per-channel level request
//   ch_read_address         : per-channel word address, channel i in slice i
//   ch_read_data            : last fetched word, broadcast to all channels
//   ch_read_finished_strobe : one-hot single-cycle completion strobe
//   mem_addr / mem_rd_en    : memory read address and single-cycle read pulse
//   mem_rd_data             : memory read data
// Modports: master = arbiter side, slave = channels + memory side.
interface icnd_read_arbiter_if #(
  parameter int unsigned NUM_CH            = 4,
  parameter int unsigned ADDRESS_BUS_WIDTH = 12
);
  import icnd_pkg::*;

  logic [NUM_CH-1:0]                   ch_read_request;
  logic [NUM_CH*ADDRESS_BUS_WIDTH-1:0] ch_read_address;
  logic [WordWidth-1:0]                ch_read_data;
  logic [NUM_CH-1:0]                   ch_read_finished_strobe;
  logic [ADDRESS_BUS_WIDTH-1:0]        mem_addr;
  logic                                mem_rd_en;
  logic [WordWidth-1:0]                mem_rd_data;

  modport master (
    input  ch_read_request, ch_read_address, mem_rd_data,
    output ch_read_data, ch_read_finished_strobe, mem_addr, mem_rd_en
  );

  modport slave (
    output ch_read_request, ch_read_address, mem_rd_data,
    input  ch_read_data, ch_read_finished_strobe, mem_addr, mem_rd_en
  );

endinterface

// File: rtl/icnd_read_arbiter_rr_select.sv
// rr_select: combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : index searched first
//   valid_o : any request present
//   idx_o   : first requesting index at or after ptr_i, wrapping
module rr_select import icnd_pkg::*; #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IdxW   = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic              valid_o,
  output logic [IdxW-1:0]   idx_o
);

  int unsigned   cand;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand     = (32'(ptr_i) + k) % NUM_CH;
      cand_idx = IdxW'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/icnd_read_arbiter.sv
// icnd_read_arbiter: shares one frame-memory read port among NUM_CH LED channels.
// One read in flight at a time: IDLE grants (round-robin), ISSUE pulses mem_rd_en,
// WAIT counts out MEM_LATENCY (legal 1..7), DONE strobes the granted channel.
//   clk, rst : clock and synchronous active-high reset
//   bus      : icnd_read_arbiter_if master modport (channel + memory signals)
//   ch_grant_count : present only with ICND_ARB_STATS_EN defined; per-channel
//                    16-bit completed-read counters, channel i in slice i
module icnd_read_arbiter import icnd_pkg::*; #(
  parameter int unsigned NUM_CH            = 4,
  parameter int unsigned ADDRESS_BUS_WIDTH = 12,
  parameter int unsigned MEM_LATENCY       = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  icnd_read_arbiter_if.master         bus
`ifdef ICND_ARB_STATS_EN
  ,
  output logic [NUM_CH*StatWidth-1:0] ch_grant_count
`endif
);

  localparam int unsigned IdxW = idx_width(NUM_CH);
  localparam int unsigned CntW = 3;

  arb_state_e                   state_q, state_d;
  logic [IdxW-1:0]              grant_idx_q, grant_idx_d;
  logic [IdxW-1:0]              ptr_q, ptr_d;
  logic [ADDRESS_BUS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WordWidth-1:0]         rd_data_q, rd_data_d;
  logic [CntW-1:0]              wait_cnt_q, wait_cnt_d;

  logic            rr_valid;
  logic [IdxW-1:0] rr_idx;
  logic [NUM_CH-1:0] strobe;

  rr_select #(
    .NUM_CH (NUM_CH),
    .IdxW   (IdxW)
  ) u_rr_select (
    .req_i   (bus.ch_read_request),
    .ptr_i   (ptr_q),
    .valid_o (rr_valid),
    .idx_o   (rr_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;
    mem_addr_d  = mem_addr_q;
    rd_data_d   = rd_data_q;
    wait_cnt_d  = wait_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (rr_valid) begin
          grant_idx_d = rr_idx;
          // Address latched here so later changes on the channel side are ignored.
          mem_addr_d  = bus.ch_read_address[rr_idx*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH];
          ptr_d       = (rr_idx == IdxW'(NUM_CH - 1)) ? '0 : rr_idx + 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        wait_cnt_d = CntW'(MEM_LATENCY - 1);
        state_d    = StWait;
      end
      StWait: begin
        if (wait_cnt_q == '0) begin
          rd_data_d = bus.mem_rd_data;
          state_d   = StDone;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_idx_q <= '0;
      ptr_q       <= '0;
      mem_addr_q  <= '0;
      rd_data_q   <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
      mem_addr_q  <= mem_addr_d;
      rd_data_q   <= rd_data_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // Pulses are masked during rst so an aborted read never strobes in the reset cycle.
  always_comb begin
    strobe = '0;
    if (state_q == StDone && !rst) begin
      strobe[grant_idx_q] = 1'b1;
    end
  end

  assign bus.ch_read_finished_strobe = strobe;
  assign bus.mem_rd_en               = (state_q == StIssue) && !rst;
  assign bus.mem_addr                = mem_addr_q;
  assign bus.ch_read_data            = rd_data_q;

`ifdef ICND_ARB_STATS_EN
  logic [NUM_CH-1:0][StatWidth-1:0] grant_cnt_q, grant_cnt_d;

  // Counters wrap naturally at 2^StatWidth.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if (state_q == StDone) begin
      grant_cnt_d[grant_idx_q] = grant_cnt_q[grant_idx_q] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign ch_grant_count = grant_cnt_q;
`endif

endmodule

// File: tb/tb_icnd_read_arbiter.sv
module tb_icnd_read_arbiter;
  import icnd_pkg::*;

  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 12;
  localparam int unsigned ML  = 3;
  localparam int unsigned PER = ML + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icnd_read_arbiter_if #(.NUM_CH(NCH), .ADDRESS_BUS_WIDTH(AW)) bus ();

`ifdef ICND_ARB_STATS_EN
  logic [NCH*16-1:0] ch_grant_count;
`endif

  icnd_read_arbiter #(
    .NUM_CH            (NCH),
    .ADDRESS_BUS_WIDTH (AW),
    .MEM_LATENCY       (ML)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ICND_ARB_STATS_EN
    ,
    .ch_grant_count (ch_grant_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Frame memory with ML-cycle read pipeline; off-window data is junk.
  logic [WordWidth-1:0] mem [1 << AW];
  logic [ML-1:0]        pv = '0;
  logic [WordWidth-1:0] pd [ML];

  always @(posedge clk) begin
    pv[0] <= bus.mem_rd_en;
    pd[0] <= mem[bus.mem_addr];
    for (int i = 1; i < ML; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end
  assign bus.mem_rd_data = pv[ML-1] ? pd[ML-1] : 16'hDEAD;

  // Transaction-level reference: a grant at cycle c issues at c+1, strobes at c+2+ML,
  // and the arbiter is free again at c+3+ML.
  int                   m_cyc = 0;
  bit                   pend = 1'b0;
  int                   en_cyc, st_cyc;
  int                   next_free = 0;
  int                   ptr = 0;
  int                   p_g;
  logic [AW-1:0]        p_addr;
  logic [AW-1:0]        m_addr;
  logic [WordWidth-1:0] p_data, m_data;
  logic                 exp_en;
  logic [NCH-1:0]       exp_strobe;
  int                   m_cnt [NCH];

  task automatic model_step();
    bit found;
    int g;
    found = 1'b0;
    g = 0;
    if (!rst && pend && m_cyc == st_cyc) m_cnt[p_g] = (m_cnt[p_g] + 1) % 65536;
    if (rst) begin
      pend = 1'b0;
      next_free = m_cyc + 1;
      ptr = 0;
      m_addr = '0;
      m_data = '0;
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    end else if (m_cyc >= next_free) begin
      for (int k = 0; k < NCH; k++) begin
        if (!found && bus.ch_read_request[(ptr + k) % NCH] === 1'b1) begin
          found = 1'b1;
          g = (ptr + k) % NCH;
        end
      end
      if (found) begin
        pend = 1'b1;
        p_g = g;
        p_addr = bus.ch_read_address[g*AW +: AW];
        p_data = mem[p_addr];
        en_cyc = m_cyc + 1;
        st_cyc = m_cyc + 2 + ML;
        next_free = m_cyc + ML + 3;
        ptr = (g + 1) % NCH;
      end
    end
    m_cyc++;
    exp_en = pend && (m_cyc == en_cyc);
    if (exp_en) m_addr = p_addr;
    exp_strobe = '0;
    if (pend && m_cyc == st_cyc) begin
      exp_strobe = NCH'(1) << p_g;
      m_data = p_data;
    end
  endtask

  always @(posedge clk) model_step();

  task automatic set_addr(input int ch, input logic [AW-1:0] a);
    bus.ch_read_address[ch*AW +: AW] = a;
  endtask

  task automatic go_idle();
    rst = 1'b0;
    bus.ch_read_request = '0;
    repeat (PER + 2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ch_read_request = '0;
    bus.ch_read_address = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.mem_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_en: got %b expected 0", bus.mem_rd_en);
    end
    n_tests++;
    if (bus.ch_read_finished_strobe !== '0) begin
      n_fail++; $display("FAIL reset_strobe: got %b expected 0", bus.ch_read_finished_strobe);
    end
    n_tests++;
    if (bus.mem_addr !== '0) begin
      n_fail++; $display("FAIL reset_addr: got %h expected 0", bus.mem_addr);
    end
    n_tests++;
    if (bus.ch_read_data !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", bus.ch_read_data);
    end
  endtask

  task automatic test_single();
    logic [AW-1:0]  a;
    logic [NCH-1:0] es;
    a = 12'h005;
    go_idle();
    set_addr(1, a);
    bus.ch_read_request = 4'b0010;
    for (int k = 1; k <= int'(PER); k++) begin
      @(negedge clk);
      n_tests++;
      if (bus.mem_rd_en !== (k == 1)) begin
        n_fail++; $display("FAIL single_en k=%0d: got %b expected %b", k, bus.mem_rd_en, k == 1);
      end
      if (k == 1) begin
        n_tests++;
        if (bus.mem_addr !== a) begin
          n_fail++; $display("FAIL single_addr: got %h expected %h", bus.mem_addr, a);
        end
        bus.ch_read_request = '0;
      end
      es = (k == 2 + int'(ML)) ? 4'b0010 : 4'b0000;
      n_tests++;
      if (bus.ch_read_finished_strobe !== es) begin
        n_fail++;
        $display("FAIL single_strobe k=%0d: got %b expected %b", k, bus.ch_read_finished_strobe, es);
      end
      if (k == 2 + int'(ML)) begin
        n_tests++;
        if (bus.ch_read_data !== mem[a]) begin
          n_fail++; $display("FAIL single_data: got %h expected %h", bus.ch_read_data, mem[a]);
        end
      end
    end
  endtask

  task automatic test_addr_change();
    logic [AW-1:0]  a;
    logic [NCH-1:0] es;
    a = AW'($urandom);
    go_idle();
    set_addr(2, a);
    bus.ch_read_request = 4'b0100;
    for (int k = 1; k <= int'(PER) + 2; k++) begin
      @(negedge clk);
      n_tests++;
      if (bus.mem_rd_en !== (k == 1)) begin
        n_fail++; $display("FAIL chg_en k=%0d: got %b expected %b", k, bus.mem_rd_en, k == 1);
      end
      if (k == 1) begin
        bus.ch_read_request = '0;
        set_addr(2, a ^ 12'hFFF);
      end
      n_tests++;
      if (bus.mem_addr !== a) begin
        n_fail++; $display("FAIL chg_addr k=%0d: got %h expected %h", k, bus.mem_addr, a);
      end
      es = (k == 2 + int'(ML)) ? 4'b0100 : 4'b0000;
      n_tests++;
      if (bus.ch_read_finished_strobe !== es) begin
        n_fail++;
        $display("FAIL chg_strobe k=%0d: got %b expected %b", k, bus.ch_read_finished_strobe, es);
      end
      if (k >= 2 + int'(ML)) begin
        n_tests++;
        if (bus.ch_read_data !== mem[a]) begin
          n_fail++; $display("FAIL chg_data k=%0d: got %h expected %h", k, bus.ch_read_data, mem[a]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0]  a [NCH];
    logic [NCH-1:0] es;
    int t, n, last;
    t = 0; n = 0; last = 0;
    for (int i = 0; i < NCH; i++) begin
      a[i] = AW'($urandom);
      set_addr(i, a[i]);
    end
    rst = 1'b1;
    bus.ch_read_request = '0;
    @(negedge clk);
    rst = 1'b0;
    bus.ch_read_request = '1;
    while (n < 8 && t < 3 * int'(NCH * PER)) begin
      @(negedge clk);
      t++;
      if (bus.ch_read_finished_strobe !== '0) begin
        es = NCH'(1) << (n % NCH);
        n_tests++;
        if (bus.ch_read_finished_strobe !== es) begin
          n_fail++;
          $display("FAIL rr_order n=%0d: got %b expected %b", n, bus.ch_read_finished_strobe, es);
        end
        n_tests++;
        if (bus.ch_read_data !== mem[a[n % NCH]]) begin
          n_fail++;
          $display("FAIL rr_data n=%0d: got %h expected %h", n, bus.ch_read_data, mem[a[n % NCH]]);
        end
        if (n > 0) begin
          n_tests++;
          if (t - last != int'(PER)) begin
            n_fail++; $display("FAIL rr_spacing n=%0d: got %0d expected %0d", n, t - last, PER);
          end
        end
        last = t;
        n++;
      end
    end
    n_tests++;
    if (n < 8) begin
      n_fail++; $display("FAIL rr_count: got %0d strobes expected 8", n);
    end
    bus.ch_read_request = '0;
  endtask

  task automatic test_sole_requester();
    int t, n, last;
    t = 0; n = 0; last = 0;
    go_idle();
    set_addr(3, AW'($urandom));
    bus.ch_read_request = 4'b1000;
    while (n < 4 && t < 5 * int'(PER) + 4) begin
      @(negedge clk);
      t++;
      if (bus.ch_read_finished_strobe !== '0) begin
        n_tests++;
        if (bus.ch_read_finished_strobe !== 4'b1000) begin
          n_fail++; $display("FAIL sole_strobe: got %b expected 1000", bus.ch_read_finished_strobe);
        end
        if (n > 0) begin
          n_tests++;
          if (t - last != int'(PER)) begin
            n_fail++; $display("FAIL sole_spacing n=%0d: got %0d expected %0d", n, t - last, PER);
          end
        end
        last = t;
        n++;
      end
    end
    n_tests++;
    if (n < 4) begin
      n_fail++; $display("FAIL sole_count: got %0d strobes expected 4", n);
    end
    bus.ch_read_request = '0;
  endtask

  task automatic test_reset_abort();
    logic [AW-1:0]  a1, a3;
    logic [NCH-1:0] es;
    a1 = AW'($urandom);
    a3 = a1 ^ 12'hA5A;
    go_idle();
    set_addr(1, a1);
    set_addr(3, a3);
    bus.ch_read_request = 4'b0010;
    repeat (2) @(negedge clk);
    // First WAIT cycle: abort, and have ch1 and ch3 requesting across the reset.
    rst = 1'b1;
    bus.ch_read_request = 4'b1010;
    for (int k = 3; k <= 5 + int'(ML); k++) begin
      @(negedge clk);
      if (k == 3) begin
        n_tests++;
        if (bus.mem_addr !== '0 || bus.ch_read_data !== '0) begin
          n_fail++;
          $display("FAIL abort_regs: got addr %h data %h expected 0 0", bus.mem_addr, bus.ch_read_data);
        end
        rst = 1'b0;
      end
      n_tests++;
      if (bus.mem_rd_en !== (k == 4)) begin
        n_fail++; $display("FAIL abort_en k=%0d: got %b expected %b", k, bus.mem_rd_en, k == 4);
      end
      if (k == 4) begin
        n_tests++;
        if (bus.mem_addr !== a1) begin
          n_fail++; $display("FAIL abort_grant_addr: got %h expected %h", bus.mem_addr, a1);
        end
      end
      es = (k == 5 + int'(ML)) ? 4'b0010 : 4'b0000;
      n_tests++;
      if (bus.ch_read_finished_strobe !== es) begin
        n_fail++;
        $display("FAIL abort_strobe k=%0d: got %b expected %b", k, bus.ch_read_finished_strobe, es);
      end
    end
    bus.ch_read_request = '0;
  endtask

  task automatic test_random();
    logic           ee;
    logic [NCH-1:0] es;
    go_idle();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      ee = exp_en && !rst;
      es = rst ? '0 : exp_strobe;
      n_tests++;
      if (bus.mem_rd_en !== ee) begin
        n_fail++; $display("FAIL rand_en c=%0d: got %b expected %b", c, bus.mem_rd_en, ee);
      end
      n_tests++;
      if (bus.ch_read_finished_strobe !== es) begin
        n_fail++;
        $display("FAIL rand_strobe c=%0d: got %b expected %b", c, bus.ch_read_finished_strobe, es);
      end
      n_tests++;
      if (bus.mem_addr !== m_addr) begin
        n_fail++; $display("FAIL rand_addr c=%0d: got %h expected %h", c, bus.mem_addr, m_addr);
      end
      n_tests++;
      if (bus.ch_read_data !== m_data) begin
        n_fail++; $display("FAIL rand_data c=%0d: got %h expected %h", c, bus.ch_read_data, m_data);
      end
      rst = ($urandom_range(0, 59) == 0);
      bus.ch_read_request = NCH'($urandom);
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 3) == 0) set_addr(i, AW'($urandom));
      end
    end
    rst = 1'b0;
    bus.ch_read_request = '0;
  endtask

`ifdef ICND_ARB_STATS_EN
  task automatic test_stats();
    go_idle();
    for (int i = 0; i < NCH; i++) begin
      n_tests++;
      if (ch_grant_count[i*16 +: 16] !== 16'(m_cnt[i])) begin
        n_fail++;
        $display("FAIL stats_ch%0d: got %0d expected %0d", i, ch_grant_count[i*16 +: 16], m_cnt[i]);
      end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = WordWidth'($urandom);
    for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    test_reset();
    test_single();
    test_addr_change();
    test_round_robin();
    test_sole_requester();
    test_reset_abort();
    test_random();
`ifdef ICND_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
